// File: rtl/half_adder_monitor.sv
// Half adder checker: runs a session of qualified samples against a 1-bit
// adder, counts mismatches and completes once all four operand pairs are seen.
// Optional macro HAM_FIRST_FAIL_CAPTURE_EN adds first_fail/first_fail_vld.
module half_adder_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       cov
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [3:0]       first_fail,
    output logic             first_fail_vld
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [3:0]       cov_q, cov_d;
    logic             accept;
    logic             mismatch;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
    logic [3:0]       first_fail_q, first_fail_d;
    logic             first_fail_vld_q, first_fail_vld_d;
`endif

    // Next-state, counter and coverage update for one clock edge
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        cov_d        = cov_q;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
`endif
        // start wins over a sample arriving in the same cycle
        accept   = (state_q == S_RUN) && sample_valid && !start;
        mismatch = (sum != (a ^ b)) || (carry != (a & b));

        if (start) begin
            state_d      = S_RUN;
            sample_cnt_d = '0;
            fail_cnt_d   = '0;
            cov_d        = '0;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
            first_fail_d     = '0;
            first_fail_vld_d = 1'b0;
`endif
        end else if (accept) begin
            if (sample_cnt_q != CNT_MAX) begin
                sample_cnt_d = sample_cnt_q + CNT_ONE;
            end
            if (mismatch && (fail_cnt_q != CNT_MAX)) begin
                fail_cnt_d = fail_cnt_q + CNT_ONE;
            end
            cov_d = cov_q | (4'b0001 << {a, b});
            if (cov_d == 4'b1111) begin
                state_d = S_DONE;
            end
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
            if (mismatch && !first_fail_vld_q) begin
                first_fail_d     = {a, b, sum, carry};
                first_fail_vld_d = 1'b1;
            end
`endif
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (fail_cnt_d == '0);
    end

    // State and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sample_cnt_q <= '0;
            fail_cnt_q   <= '0;
            cov_q        <= '0;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            sample_cnt_q <= sample_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            cov_q        <= cov_d;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign sample_cnt = sample_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign cov        = cov_q;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;
`endif

endmodule

// File: tb/tb_half_adder_monitor.sv
// Bench for half_adder_monitor: directed table, corner sequences and random
// traffic against a session model, on an 8-bit and a 2-bit counter instance.
module tb_half_adder_monitor;

    logic clk = 1'b0;
    logic rst, start, sample_valid, a, b, sum, carry;

    logic       busy8, done8, pass8;
    logic [7:0] scnt8, fcnt8;
    logic [3:0] cov8;
    logic       busy2, done2, pass2;
    logic [1:0] scnt2, fcnt2;
    logic [3:0] cov2;
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
    logic [3:0] ff8, ff2;
    logic       ffv8, ffv2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_adder_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .sum(sum), .carry(carry),
        .busy(busy8), .done(done8), .pass(pass8),
        .sample_cnt(scnt8), .fail_cnt(fcnt8), .cov(cov8)
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
        , .first_fail(ff8), .first_fail_vld(ffv8)
`endif
    );

    half_adder_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .sum(sum), .carry(carry),
        .busy(busy2), .done(done2), .pass(pass2),
        .sample_cnt(scnt2), .fail_cnt(fcnt2), .cov(cov2)
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
        , .first_fail(ff2), .first_fail_vld(ffv2)
`endif
    );

    // Session model: 0 idle, 1 run, 2 done; counts kept unbounded
    int       m_state;
    int       m_cnt;
    int       m_fail;
    bit [3:0] m_cov;
    bit [3:0] m_ff;
    bit       m_ffv;

    task automatic model_edge();
        int s_exp, c_exp;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_fail = 0;
            m_cov = 0; m_ff = 0; m_ffv = 0;
        end else if (start) begin
            m_state = 1; m_cnt = 0; m_fail = 0;
            m_cov = 0; m_ff = 0; m_ffv = 0;
        end else if (m_state == 1 && sample_valid) begin
            s_exp = (int'(a) + int'(b)) % 2;
            c_exp = (int'(a) + int'(b)) / 2;
            m_cnt++;
            if (int'(sum) != s_exp || int'(carry) != c_exp) begin
                m_fail++;
                if (!m_ffv) begin
                    m_ff = {a, b, sum, carry};
                    m_ffv = 1;
                end
            end
            m_cov[int'(a) * 2 + int'(b)] = 1'b1;
            if (m_cov == 4'hf) m_state = 2;
        end
    endtask

    function automatic int sat(int n, int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int pass_e;
        pass_e = (m_state == 2 && m_fail == 0) ? 1 : 0;
        chk("busy8", int'(busy8), int'(m_state == 1));
        chk("done8", int'(done8), int'(m_state == 2));
        chk("pass8", int'(pass8), pass_e);
        chk("scnt8", int'(scnt8), sat(m_cnt, 255));
        chk("fcnt8", int'(fcnt8), sat(m_fail, 255));
        chk("cov8", int'(cov8), int'(m_cov));
        chk("busy2", int'(busy2), int'(m_state == 1));
        chk("done2", int'(done2), int'(m_state == 2));
        chk("pass2", int'(pass2), pass_e);
        chk("scnt2", int'(scnt2), sat(m_cnt, 3));
        chk("fcnt2", int'(fcnt2), sat(m_fail, 3));
        chk("cov2", int'(cov2), int'(m_cov));
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
        chk("ff8", int'(ff8), int'(m_ff));
        chk("ffv8", int'(ffv8), int'(m_ffv));
        chk("ff2", int'(ff2), int'(m_ff));
        chk("ffv2", int'(ffv2), int'(m_ffv));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge
    task automatic cyc(bit r, bit st, bit sv, bit [3:0] abcs);
        rst = r; start = st; sample_valid = sv;
        {a, b, sum, carry} = abcs;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit       r, st, sv;
        bit [3:0] abcs;
        bit       busy, done, pass;
        int       cnt, fail;
        bit [3:0] cov;
    } vec_t;

    vec_t tbl[23];

    initial begin
        rst = 1; start = 0; sample_valid = 0;
        a = 0; b = 0; sum = 0; carry = 0;
        m_state = 0; m_cnt = 0; m_fail = 0;
        m_cov = 0; m_ff = 0; m_ffv = 0;

        // r st sv abcs | busy done pass cnt fail cov
        tbl[0]  = '{1,0,0,4'b0000, 0,0,0, 0,0,4'b0000};
        tbl[1]  = '{0,1,0,4'b0000, 1,0,0, 0,0,4'b0000};
        tbl[2]  = '{0,0,1,4'b0000, 1,0,0, 1,0,4'b0001};
        tbl[3]  = '{0,0,1,4'b0110, 1,0,0, 2,0,4'b0011};
        tbl[4]  = '{0,0,1,4'b1010, 1,0,0, 3,0,4'b0111};
        tbl[5]  = '{0,0,1,4'b1101, 0,1,1, 4,0,4'b1111};
        tbl[6]  = '{0,0,0,4'b0000, 0,1,1, 4,0,4'b1111};
        tbl[7]  = '{0,0,1,4'b1110, 0,1,1, 4,0,4'b1111};
        tbl[8]  = '{0,1,0,4'b0000, 1,0,0, 0,0,4'b0000};
        tbl[9]  = '{0,0,1,4'b0000, 1,0,0, 1,0,4'b0001};
        tbl[10] = '{0,0,1,4'b0110, 1,0,0, 2,0,4'b0011};
        tbl[11] = '{0,0,1,4'b1010, 1,0,0, 3,0,4'b0111};
        tbl[12] = '{0,0,1,4'b1110, 0,1,0, 4,1,4'b1111};
        tbl[13] = '{1,0,0,4'b0000, 0,0,0, 0,0,4'b0000};
        tbl[14] = '{0,0,1,4'b0000, 0,0,0, 0,0,4'b0000};
        tbl[15] = '{0,0,1,4'b0110, 0,0,0, 0,0,4'b0000};
        tbl[16] = '{0,0,1,4'b1101, 0,0,0, 0,0,4'b0000};
        tbl[17] = '{0,1,0,4'b0000, 1,0,0, 0,0,4'b0000};
        tbl[18] = '{0,0,1,4'b0000, 1,0,0, 1,0,4'b0001};
        tbl[19] = '{0,0,1,4'b0000, 1,0,0, 2,0,4'b0001};
        tbl[20] = '{0,0,1,4'b0110, 1,0,0, 3,0,4'b0011};
        tbl[21] = '{0,0,1,4'b1010, 1,0,0, 4,0,4'b0111};
        tbl[22] = '{0,0,1,4'b1101, 0,1,1, 5,0,4'b1111};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].r, tbl[i].st, tbl[i].sv, tbl[i].abcs);
            chk($sformatf("t%0d_busy", i), int'(busy8), int'(tbl[i].busy));
            chk($sformatf("t%0d_done", i), int'(done8), int'(tbl[i].done));
            chk($sformatf("t%0d_pass", i), int'(pass8), int'(tbl[i].pass));
            chk($sformatf("t%0d_cnt", i), int'(scnt8), tbl[i].cnt);
            chk($sformatf("t%0d_fail", i), int'(fcnt8), tbl[i].fail);
            chk($sformatf("t%0d_cov", i), int'(cov8), int'(tbl[i].cov));
`ifdef HAM_FIRST_FAIL_CAPTURE_EN
            if (i == 12) begin
                chk("faulty_ff", int'(ff8), 4'b1110);
                chk("faulty_ffv", int'(ffv8), 1);
            end
`endif
        end

        // Restart colliding with a sample mid-run
        cyc(0, 1, 0, 4'b0000);
        cyc(0, 0, 1, 4'b0000);
        cyc(0, 0, 1, 4'b0110);
        cyc(0, 1, 1, 4'b1010);
        chk("restart_cnt", int'(scnt8), 0);
        chk("restart_cov", int'(cov8), 0);
        chk("restart_busy", int'(busy8), 1);

        // Saturation of the 2-bit counters, holding afterwards
        cyc(0, 1, 0, 4'b0000);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'b0001);
        chk("sat_fail2", int'(fcnt2), 3);
        chk("sat_cnt2", int'(scnt2), 3);
        chk("sat_fail8", int'(fcnt8), 5);
        cyc(0, 0, 0, 4'b0000);
        cyc(0, 0, 0, 4'b0000);
        chk("sat_hold_fail2", int'(fcnt2), 3);
        chk("sat_hold_cnt2", int'(scnt2), 3);

        // Reset mid-run after a mismatch, with samples around it
        cyc(0, 1, 0, 4'b0000);
        cyc(0, 0, 1, 4'b1100);
        cyc(1, 0, 1, 4'b0000);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_cnt", int'(scnt8), 0);
        chk("rst_fail", int'(fcnt8), 0);
        cyc(0, 0, 1, 4'b0110);
        chk("rst_idle_cnt", int'(scnt8), 0);
        chk("rst_idle_cov", int'(cov8), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit r, st, sv, aa, bb, ss, cc;
            r  = ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 15) == 0);
            sv = ($urandom_range(0, 3) != 0);
            aa = 1'($urandom_range(0, 1));
            bb = 1'($urandom_range(0, 1));
            ss = aa ^ bb;
            cc = aa & bb;
            if ($urandom_range(0, 7) == 0) ss = ~ss;
            if ($urandom_range(0, 7) == 0) cc = ~cc;
            cyc(r, st, sv, {aa, bb, ss, cc});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
